// File: rtl/spi_tx_scheduler.sv
// -----------------------------------------------------------------------------
// spi_tx_scheduler
//   Upstream feeder for the SPI master/slave top. Words are buffered in a small
//   FIFO and handed to the SPI master one at a time on din/newd. The next word
//   is only issued after the SPI top reports done (synchronized into clk) and
//   a fixed idle gap has elapsed. Lost transfers (no done within TIMEOUT) and
//   writes into a full FIFO are flagged with sticky error bits.
//
// Parameters
//   DEPTH    FIFO entries (power of two, >= 2)
//   DW       word width, matches the SPI top din width
//   TIMEOUT  clk cycles allowed from newd to done
//   GAP_CYC  idle cycles forced between transfers (>= 1)
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   wr_en, wr_data FIFO push
//   clr_err        pulse: clears overflow, timeout_err (and mismatch)
//   done           transfer complete from SPI top, asynchronous to clk
//   din, newd      word to SPI master and its 1-cycle start pulse
//   full, empty, count   FIFO status
//   busy           FSM not idle
//   overflow       sticky: write attempted while full
//   timeout_err    sticky: done not seen within TIMEOUT
//
// Optional feature (macro SPI_TX_LOOPBACK_CHECK_EN)
//   Adds dout (in) and mismatch (out, sticky). On an accepted done, the word
//   echoed back on dout is compared with din.
// -----------------------------------------------------------------------------
module spi_tx_scheduler #(
    parameter int DEPTH   = 8,
    parameter int DW      = 12,
    parameter int TIMEOUT = 1024,
    parameter int GAP_CYC = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DW-1:0]              wr_data,
    input  logic                       clr_err,
    input  logic                       done,
`ifdef SPI_TX_LOOPBACK_CHECK_EN
    input  logic [DW-1:0]              dout,
    output logic                       mismatch,
`endif
    output logic [DW-1:0]              din,
    output logic                       newd,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy,
    output logic                       overflow,
    output logic                       timeout_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

    // ---------------- FIFO ----------------
    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop;

    state_t        state_q, state_d;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // full is the registered occupancy, so a same-cycle pop never makes room
    assign push = wr_en && !full;
    assign pop  = (state_q == IDLE) && !empty;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_data;
    end

    // pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // ---------------- done synchronizer ----------------
    // [0],[1] are the two-flop synchronizer, [2] is history for edge detect
    logic [2:0] sync_q;
    logic       done_rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[1:0], done};
    end

    assign done_rise = sync_q[1] && !sync_q[2];

    // ---------------- FSM ----------------
    logic [TW-1:0] tmo_q, tmo_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [DW-1:0] din_q, din_d;
    logic          tmo_evt;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        gap_d   = gap_q;
        din_d   = din_q;
        tmo_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    din_d   = mem_q[rptr_q];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                tmo_d = tmo_q + TW'(1);
                // done wins over a coincident timeout
                if (done_rise) begin
                    gap_d   = '0;
                    state_d = GAP;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    tmo_evt = 1'b1;
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == GW'(GAP_CYC - 1)) state_d = IDLE;
                else                           gap_d   = gap_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            gap_q   <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
            din_q   <= din_d;
        end
    end

    assign din  = din_q;
    assign newd = (state_q == ISSUE);
    assign busy = (state_q != IDLE);

    // ---------------- sticky error flags ----------------
    // a new error event takes priority over a coincident clr_err
    logic ovf_q, terr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            terr_q <= 1'b0;
        end else begin
            if (wr_en && full)  ovf_q <= 1'b1;
            else if (clr_err)   ovf_q <= 1'b0;
            if (tmo_evt)        terr_q <= 1'b1;
            else if (clr_err)   terr_q <= 1'b0;
        end
    end

    assign overflow    = ovf_q;
    assign timeout_err = terr_q;

`ifdef SPI_TX_LOOPBACK_CHECK_EN
    logic mis_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                            mis_q <= 1'b0;
        else if (state_q == WAIT && done_rise && dout != din_q) mis_q <= 1'b1;
        else if (clr_err)                                   mis_q <= 1'b0;
    end

    assign mismatch = mis_q;
`endif

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Scoreboard bench for spi_tx_scheduler. Every accepted word is pushed into
// exp_q when written; the monitor pops and compares whenever newd appears.
// A responder answers each newd with done after a random or fixed delay.
module tb_spi_tx_scheduler;
    localparam int DEPTH   = 8;
    localparam int DW      = 12;
    localparam int TIMEOUT = 64;
    localparam int GAP_CYC = 4;
    localparam int CW      = $clog2(DEPTH + 1);

    logic          clk, rst, wr_en, clr_err, done;
    logic [DW-1:0] wr_data, din;
    logic          newd, full, empty, busy, overflow, timeout_err;
    logic [CW-1:0] count;
`ifdef SPI_TX_LOOPBACK_CHECK_EN
    logic [DW-1:0] dout;
    logic          mismatch;
    bit            corrupt;
`endif

    spi_tx_scheduler #(.DEPTH(DEPTH), .DW(DW), .TIMEOUT(TIMEOUT), .GAP_CYC(GAP_CYC)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .clr_err(clr_err),
        .done(done),
`ifdef SPI_TX_LOOPBACK_CHECK_EN
        .dout(dout), .mismatch(mismatch),
`endif
        .din(din), .newd(newd), .full(full), .empty(empty), .count(count),
        .busy(busy), .overflow(overflow), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int cyc = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_din;
    int  n_newd = 0, newd_cyc = 0, done_cyc = -1000;
    bit  prev_newd = 0;
    bit  resp_en = 1;
    int  resp_fixed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each newd and checks ordering, pulse
    // width, minimum spacing from the last done and din stability.
    always @(negedge clk) begin
        if (rst) begin
            prev_newd = 0;
        end else if (newd) begin
            chk("newd_single_cycle", prev_newd, 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_newd", 1, 0);
            end else begin
                chk("din_order", din, exp_q.pop_front());
            end
            // done driven in cycle R: done_rise in R+2, GAP from R+3 for
            // GAP_CYC cycles, IDLE pop at R+3+GAP_CYC, earliest newd R+4+GAP_CYC
            chk("gap_after_done", (cyc - done_cyc) >= GAP_CYC + 4, 1);
            last_din = din;
            newd_cyc = cyc;
            n_newd++;
            prev_newd = 1;
        end else begin
            if (din !== last_din) chk("din_hold", din, last_din);
            prev_newd = 0;
        end
    end

    // Responder: models the SPI top returning done some time after newd.
    initial begin
        forever begin
            @(negedge clk);
            if (newd && resp_en && !rst) begin
                automatic int d = (resp_fixed > 0) ? resp_fixed : int'($urandom_range(1, 40));
                repeat (d) @(negedge clk);
`ifdef SPI_TX_LOOPBACK_CHECK_EN
                dout = corrupt ? (din ^ 12'h001) : din;
`endif
                done = 1;
                done_cyc = cyc;
                repeat (3) @(negedge clk);
                done = 0;
            end
        end
    end

    task automatic wr(input logic [DW-1:0] w, input bit accept);
        wr_en = 1;
        wr_data = w;
        if (accept) exp_q.push_back(w);
        @(negedge clk);
    endtask

    task automatic idle_cyc();
        wr_en = 0;
        @(negedge clk);
    endtask

    task automatic wait_newd(input int target, input string nm);
        int k = 0;
        while (n_newd < target && k < 500) begin
            @(negedge clk);
            k++;
        end
        chk(nm, n_newd >= target, 1);
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int k = 0;
        while ((exp_q.size() != 0 || busy) && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk(nm, (exp_q.size() == 0) && !busy, 1);
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr_err = 1;
        @(negedge clk);
        clr_err = 0;
    endtask

    initial begin
        int n0, wr_cyc, k, low_cyc, t_newd, terr_cyc;
        clk = 0; rst = 1; wr_en = 0; wr_data = '0; clr_err = 0; done = 0;
`ifdef SPI_TX_LOOPBACK_CHECK_EN
        dout = '0; corrupt = 0;
`endif
        last_din = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_newd", newd, 0);
        chk("rst_din", din, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", timeout_err, 0);
        rst = 0;
        @(negedge clk);

        // single word: latency, done-to-idle timing, din held afterwards
        resp_fixed = 30;
        wr_cyc = cyc;
        wr(12'hA5C, 1);
        wr_en = 0;
        wait_newd(1, "a5c_newd_seen");
        chk("a5c_latency", newd_cyc - wr_cyc, 2);
        k = 0;
        while (done_cyc < newd_cyc && k < 100) begin @(negedge clk); k++; end
        k = 0;
        while (busy && k < 100) begin @(negedge clk); k++; end
        low_cyc = cyc;
        chk("a5c_busy_drop", (low_cyc - done_cyc >= GAP_CYC + 2) && (low_cyc - done_cyc <= GAP_CYC + 3), 1);
        chk("a5c_din_held", din, 12'hA5C);
        repeat (4) @(negedge clk);

        // three words back to back
        resp_fixed = 0;
        wr(12'h001, 1); wr(12'h002, 1); wr(12'h003, 1);
        wr_en = 0;
        wait_idle(1000, "b2b_drained");

        // random traffic; only write while the FIFO cannot be full
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0 && exp_q.size() < DEPTH)
                wr(DW'($urandom), 1);
            else
                idle_cyc();
        end
        wr_en = 0;
        wait_idle(3000, "rand_drained");
        chk("rand_no_overflow", overflow, 0);
        chk("rand_no_timeout", timeout_err, 0);

        // stalled transfer: fill FIFO, overflow, clear, then timeout
        resp_en = 0;
        n0 = n_newd;
        wr(12'h7FF, 1);
        wr_en = 0;
        wait_newd(n0 + 1, "tmo_newd_seen");
        t_newd = newd_cyc;
        for (int i = 0; i < DEPTH + 1; i++) wr(DW'($urandom), i < DEPTH);
        wr_en = 0;
        chk("ovf_full", full, 1);
        chk("ovf_count", count, DEPTH);
        chk("ovf_flag", overflow, 1);
        pulse_clr();
        chk("ovf_cleared", overflow, 0);
        k = 0;
        while (!timeout_err && k < 4 * TIMEOUT) begin @(negedge clk); k++; end
        terr_cyc = cyc;
        chk("tmo_flag", timeout_err, 1);
        // err registers on the edge after the last WAIT cycle (count TIMEOUT-1)
        chk("tmo_delay", terr_cyc - t_newd, TIMEOUT + 1);
        resp_en = 1;
        wait_idle(3000, "tmo_drained");
        chk("tmo_still_set", timeout_err, 1);
        pulse_clr();
        chk("tmo_cleared", timeout_err, 0);

        // reset during WAIT with three words queued
        resp_en = 0;
        n0 = n_newd;
        for (int i = 0; i < 4; i++) wr(DW'($urandom), 1);
        wr_en = 0;
        wait_newd(n0 + 1, "rstw_newd_seen");
        @(negedge clk);
        chk("rstw_count_before", count, 3);
        rst = 1;
        #1;
        chk("rstw_newd", newd, 0);
        chk("rstw_din", din, 0);
        chk("rstw_count", count, 0);
        chk("rstw_empty", empty, 1);
        chk("rstw_busy", busy, 0);
        exp_q.delete();
        last_din = '0;
        @(negedge clk);
        rst = 0;
        repeat (40) @(negedge clk);
        chk("rstw_no_newd", n_newd, n0 + 1);
        resp_en = 1;

`ifdef SPI_TX_LOOPBACK_CHECK_EN
        corrupt = 1;
        wr(12'h3C3, 1);
        wr_en = 0;
        wait_idle(500, "lb_bad_drained");
        chk("lb_mismatch_set", mismatch, 1);
        pulse_clr();
        chk("lb_mismatch_clr", mismatch, 0);
        corrupt = 0;
        wr(12'h3C3, 1);
        wr_en = 0;
        wait_idle(500, "lb_good_drained");
        chk("lb_mismatch_stays0", mismatch, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
